// File: rtl/digit_latch_scanner.sv
// Display back-end for the AC-mains clock: converts the live BCD time to 12h/24h form
// and serialises the six digits onto a shared 7-segment bus with per-digit latch strobes.
module digit_latch_scanner #(
  parameter int REFRESH_TICKS = 600,
  parameter bit BLANK_INVALID = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] h_tens,
  input  logic [3:0] h_ones,
  input  logic [2:0] m_tens,
  input  logic [3:0] m_ones,
  input  logic [2:0] s_tens,
  input  logic [3:0] s_ones,
  input  logic       hour_12h,
  input  logic       force_refresh,
  output logic [6:0] seg7,
  output logic [5:0] le,
  output logic       pm,
  output logic       busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SCAN = 2'd2;

  localparam int CW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
  localparam logic [CW-1:0] REF_MAX = (REFRESH_TICKS > 0) ? CW'(REFRESH_TICKS - 1) : '0;

  localparam logic [3:0] BAD_DIGIT = 4'hF;

  logic [1:0]    state;
  logic [2:0]    idx;
  logic [2:0]    next_idx;
  logic          pending;
  logic [CW-1:0] ref_cnt;
  logic [20:0]   snap;
  logic [20:0]   live_vec;
  logic [3:0]    disp [6];
  logic [3:0]    live_digit [6];

  logic [5:0] h_bin;
  logic       h_valid;
  logic [5:0] h12;
  logic [5:0] h12_ones;
  logic       pm_next;
  logic       trigger;

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    seg_pattern = 7'b1111110;
      4'd1:    seg_pattern = 7'b0110000;
      4'd2:    seg_pattern = 7'b1101101;
      4'd3:    seg_pattern = 7'b1111001;
      4'd4:    seg_pattern = 7'b0110011;
      4'd5:    seg_pattern = 7'b1011011;
      4'd6:    seg_pattern = 7'b1011111;
      4'd7:    seg_pattern = 7'b1110000;
      4'd8:    seg_pattern = 7'b1111111;
      4'd9:    seg_pattern = 7'b1111011;
      default: seg_pattern = BLANK_INVALID ? 7'b0000000 : 7'b0000001;
    endcase
  endfunction

  assign live_vec = {h_tens, h_ones, m_tens, m_ones, s_tens, s_ones, hour_12h};
  assign h_bin    = ({4'b0, h_tens} * 6'd10) + {2'b0, h_ones};
  assign h_valid  = (h_tens <= 2'd2) && (h_ones <= 4'd9) && (h_bin <= 6'd23);
  assign next_idx = idx + 3'd1;

  // Display hours: an out-of-range hour blanks both hour digits regardless of mode.
  always_comb begin
    h12           = 6'd0;
    h12_ones      = 6'd0;
    pm_next       = 1'b0;
    live_digit[0] = {2'b0, h_tens};
    live_digit[1] = h_ones;
    live_digit[2] = {1'b0, m_tens};
    live_digit[3] = m_ones;
    live_digit[4] = {1'b0, s_tens};
    live_digit[5] = s_ones;
    if (!h_valid) begin
      live_digit[0] = BAD_DIGIT;
      live_digit[1] = BAD_DIGIT;
    end else if (hour_12h) begin
      if (h_bin == 6'd0)       h12 = 6'd12;
      else if (h_bin <= 6'd12) h12 = h_bin;
      else                     h12 = h_bin - 6'd12;
      pm_next = (h_bin >= 6'd12);
      if (h12 >= 6'd10) begin
        h12_ones      = h12 - 6'd10;
        live_digit[0] = 4'd1;
      end else begin
        h12_ones      = h12;
        live_digit[0] = 4'd0;
      end
      live_digit[1] = h12_ones[3:0];
    end
  end

  assign trigger = pending || force_refresh || (live_vec != snap) ||
                   ((REFRESH_TICKS != 0) && (ref_cnt == REF_MAX));

  // Frame sequencer: LOAD captures the inputs and already drives digit 0, so each
  // SCAN tick presents digit idx while preparing idx+1 for the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 3'd0;
      seg7    <= 7'd0;
      le      <= 6'd0;
      pm      <= 1'b0;
      busy    <= 1'b0;
      pending <= 1'b1;
      ref_cnt <= '0;
      snap    <= '0;
      for (int i = 0; i < 6; i++) disp[i] <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (ref_cnt != REF_MAX) ref_cnt <= ref_cnt + CW'(1);
          if (trigger) state <= LOAD;
        end
        LOAD: begin
          snap    <= live_vec;
          for (int i = 0; i < 6; i++) disp[i] <= live_digit[i];
          pm      <= pm_next;
          pending <= force_refresh;
          ref_cnt <= '0;
          busy    <= 1'b1;
          idx     <= 3'd0;
          seg7    <= seg_pattern(live_digit[0]);
          le      <= 6'b000001;
          state   <= SCAN;
        end
        SCAN: begin
          if (force_refresh) pending <= 1'b1;
          if (idx == 3'd5) begin
            state <= IDLE;
            idx   <= 3'd0;
            seg7  <= 7'd0;
            le    <= 6'd0;
            busy  <= 1'b0;
          end else begin
            idx  <= next_idx;
            seg7 <= seg_pattern(disp[next_idx]);
            le   <= {le[4:0], 1'b0};
          end
        end
        default: begin
          state <= IDLE;
          seg7  <= 7'd0;
          le    <= 6'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_latch_scanner.sv
// Bench for digit_latch_scanner: reset/refresh/trigger timing, 12h conversion table,
// mid-frame corner cases and randomized frames checked against an arithmetic model.
module tb_digit_latch_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] h_tens;
  logic [3:0] h_ones;
  logic [2:0] m_tens;
  logic [3:0] m_ones;
  logic [2:0] s_tens;
  logic [3:0] s_ones;
  logic       hour_12h;
  logic       force_refresh;
  logic [6:0] seg7;
  logic [5:0] le;
  logic       pm;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0] ht;
    logic [3:0] ho;
    logic [2:0] mt;
    logic [3:0] mo;
    logic [2:0] st;
    logic [3:0] so;
    logic       h12;
    logic [3:0] exp_ht;
    logic [3:0] exp_ho;
    logic       exp_pm;
  } vec_t;

  vec_t tbl [8];

  digit_latch_scanner #(.REFRESH_TICKS(20), .BLANK_INVALID(1'b1)) dut (
    .clk(clk), .rst(rst), .h_tens(h_tens), .h_ones(h_ones), .m_tens(m_tens),
    .m_ones(m_ones), .s_tens(s_tens), .s_ones(s_ones), .hour_12h(hour_12h),
    .force_refresh(force_refresh), .seg7(seg7), .le(le), .pm(pm), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] segOf(input logic [3:0] d);
    case (d)
      4'd0: segOf = 7'b1111110;
      4'd1: segOf = 7'b0110000;
      4'd2: segOf = 7'b1101101;
      4'd3: segOf = 7'b1111001;
      4'd4: segOf = 7'b0110011;
      4'd5: segOf = 7'b1011011;
      4'd6: segOf = 7'b1011111;
      4'd7: segOf = 7'b1110000;
      4'd8: segOf = 7'b1111111;
      4'd9: segOf = 7'b1111011;
      default: segOf = 7'b0000000;
    endcase
  endfunction

  // Reference: clock arithmetic on the decimal hour rather than digit manipulation.
  task automatic refModel(output logic [5:0][3:0] dig, output logic pm_e);
    int hv;
    int d;
    hv = int'(h_tens) * 10 + int'(h_ones);
    pm_e = 1'b0;
    if (h_tens > 2 || h_ones > 9 || hv > 23) begin
      dig[0] = 4'hF;
      dig[1] = 4'hF;
    end else if (hour_12h) begin
      d = hv % 12;
      if (d == 0) d = 12;
      dig[0] = 4'(d / 10);
      dig[1] = 4'(d % 10);
      pm_e = (hv >= 12);
    end else begin
      dig[0] = {2'b0, h_tens};
      dig[1] = h_ones;
    end
    dig[2] = {1'b0, m_tens};
    dig[3] = m_ones;
    dig[4] = {1'b0, s_tens};
    dig[5] = s_ones;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] ht, input logic [3:0] ho, input logic [2:0] mt,
                               input logic [3:0] mo, input logic [2:0] st, input logic [3:0] so,
                               input logic h12, output bit changed);
    changed = (ht != h_tens) || (ho != h_ones) || (mt != m_tens) || (mo != m_ones) ||
              (st != s_tens) || (so != s_ones) || (h12 != hour_12h);
    h_tens = ht; h_ones = ho; m_tens = mt; m_ones = mo; s_tens = st; s_ones = so;
    hour_12h = h12;
  endtask

  // Counts falling-edge samples until le goes active; the last sample is digit 0.
  task automatic waitFrameStart(input int exp_gap, input string name);
    int gap;
    gap = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (le != 6'd0) begin
        gap = n;
        break;
      end
      checkOutput("idle_seg7", 32'(seg7), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
    end
    checkOutput(name, gap, exp_gap);
  endtask

  // act_kind 1 bumps s_ones, 2 pulses force_refresh, both right after sample act_at.
  task automatic captureFrame(input int act_at, input int act_kind,
                              output logic [5:0][6:0] pats, output logic pm_s);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      force_refresh = 1'b0;
      checkOutput($sformatf("le_strobe%0d", i), 32'(le), 32'(1 << i));
      checkOutput("scan_busy", 32'(busy), 32'd1);
      pats[i] = seg7;
      if (i == 0) pm_s = pm;
      if (i == act_at) begin
        if (act_kind == 1) s_ones = s_ones + 4'd1;
        if (act_kind == 2) force_refresh = 1'b1;
      end
    end
    @(negedge clk);
    force_refresh = 1'b0;
    checkOutput("tail_le", 32'(le), 32'd0);
    checkOutput("tail_seg7", 32'(seg7), 32'd0);
    checkOutput("tail_busy", 32'(busy), 32'd0);
  endtask

  task automatic checkFrame(input logic [5:0][6:0] pats, input logic pm_s,
                            input logic [5:0][3:0] dig, input logic pm_e);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("digit%0d", i), 32'(pats[i]), 32'(segOf(dig[i])));
    checkOutput("pm", 32'(pm_s), 32'(pm_e));
  endtask

  logic [5:0][6:0] pats;
  logic            pm_s;
  logic [5:0][3:0] dig;
  logic            pm_e;
  bit              changed;

  initial begin
    tbl[0] = '{2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0, 1'b1, 4'd1, 4'd2, 1'b0};
    tbl[1] = '{2'd1, 4'd1, 3'd0, 4'd5, 3'd0, 4'd9, 1'b1, 4'd1, 4'd1, 1'b0};
    tbl[2] = '{2'd1, 4'd2, 3'd5, 4'd9, 3'd5, 4'd9, 1'b1, 4'd1, 4'd2, 1'b1};
    tbl[3] = '{2'd1, 4'd3, 3'd0, 4'd0, 3'd0, 4'd1, 1'b1, 4'd0, 4'd1, 1'b1};
    tbl[4] = '{2'd2, 4'd3, 3'd4, 4'd5, 3'd1, 4'd0, 1'b1, 4'd1, 4'd1, 1'b1};
    tbl[5] = '{2'd2, 4'd3, 3'd4, 4'd5, 3'd1, 4'd0, 1'b0, 4'd2, 4'd3, 1'b0};
    tbl[6] = '{2'd0, 4'hB, 3'd2, 4'd2, 3'd3, 4'd3, 1'b0, 4'hF, 4'hF, 1'b0};
    tbl[7] = '{2'd2, 4'd4, 3'd0, 4'd0, 3'd0, 4'd0, 1'b1, 4'hF, 4'hF, 1'b0};

    rst = 1'b1; force_refresh = 1'b0;
    h_tens = 2'd1; h_ones = 4'd2; m_tens = 3'd3; m_ones = 4'd4;
    s_tens = 3'd5; s_ones = 4'd6; hour_12h = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("rst_seg7", 32'(seg7), 32'd0);
    checkOutput("rst_le", 32'(le), 32'd0);
    checkOutput("rst_pm", 32'(pm), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    $display("[TB] reset frame and periodic refresh");
    waitFrameStart(2, "post_reset_latency");
    captureFrame(-1, 0, pats, pm_s);
    refModel(dig, pm_e);
    checkFrame(pats, pm_s, dig, pm_e);
    repeat (2) begin
      waitFrameStart(21, "refresh_gap");
      captureFrame(-1, 0, pats, pm_s);
      checkFrame(pats, pm_s, dig, pm_e);
    end

    $display("[TB] input change in IDLE and during SCAN");
    applyStimulus(2'd1, 4'd2, 3'd3, 4'd4, 3'd5, 4'd7, 1'b0, changed);
    waitFrameStart(2, "change_latency");
    captureFrame(-1, 0, pats, pm_s);
    refModel(dig, pm_e);
    checkFrame(pats, pm_s, dig, pm_e);
    waitFrameStart(21, "refresh_gap");
    captureFrame(2, 1, pats, pm_s);
    checkFrame(pats, pm_s, dig, pm_e);
    waitFrameStart(2, "midframe_followup");
    captureFrame(-1, 0, pats, pm_s);
    refModel(dig, pm_e);
    checkOutput("so_is_8", 32'(pats[5]), 32'(segOf(4'd8)));
    checkFrame(pats, pm_s, dig, pm_e);

    $display("[TB] hour conversion table");
    for (int v = 0; v < 8; v++) begin
      applyStimulus(tbl[v].ht, tbl[v].ho, tbl[v].mt, tbl[v].mo, tbl[v].st, tbl[v].so,
                    tbl[v].h12, changed);
      waitFrameStart(changed ? 2 : 21, "table_gap");
      captureFrame(-1, 0, pats, pm_s);
      dig[0] = tbl[v].exp_ht;
      dig[1] = tbl[v].exp_ho;
      dig[2] = {1'b0, tbl[v].mt};
      dig[3] = tbl[v].mo;
      dig[4] = {1'b0, tbl[v].st};
      dig[5] = tbl[v].so;
      checkFrame(pats, pm_s, dig, tbl[v].exp_pm);
    end

    $display("[TB] force_refresh during a frame");
    refModel(dig, pm_e);
    waitFrameStart(21, "refresh_gap");
    captureFrame(3, 2, pats, pm_s);
    checkFrame(pats, pm_s, dig, pm_e);
    waitFrameStart(2, "forced_extra_frame");
    captureFrame(-1, 0, pats, pm_s);
    checkFrame(pats, pm_s, dig, pm_e);
    waitFrameStart(21, "no_second_extra");
    captureFrame(-1, 0, pats, pm_s);

    $display("[TB] randomized frames");
    for (int r = 0; r < 25; r++) begin
      applyStimulus(2'($urandom_range(0, 2)),
                    ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9)),
                    3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), changed);
      refModel(dig, pm_e);
      waitFrameStart(changed ? 2 : 21, "random_gap");
      captureFrame(-1, 0, pats, pm_s);
      checkFrame(pats, pm_s, dig, pm_e);
    end

    $display("[TB] reset in the middle of a frame");
    waitFrameStart(21, "refresh_gap");
    repeat (2) @(negedge clk);
    checkOutput("pre_rst_le", 32'(le), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_le", 32'(le), 32'd0);
    checkOutput("midrst_seg7", 32'(seg7), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    waitFrameStart(2, "post_midrst_latency");
    captureFrame(-1, 0, pats, pm_s);
    checkFrame(pats, pm_s, dig, pm_e);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/digit_latch_scanner.md
Name: digit_latch_scanner

Overview:
Display back-end of the AC-mains clock. It takes the six live BCD time digits from the timekeeping core and applies 12h/24h conversion. It then serialises the digits onto a shared {a..g} 7-segment bus, giving each digit a one-cycle latch-enable strobe for the external digit latches. clk is the AC tick (50/60 Hz). All timing below is in ticks.

Parameters:
REFRESH_TICKS, 600, ticks between unconditional refresh frames; 0 disables periodic refresh.
BLANK_INVALID, 1, 1: a digit value >9 drives all segments off; 0: it drives the segment pattern for "-" (g only).

Ports:
clk  input  1  AC tick clock
rst  input  1  synchronous active-high reset
h_tens  input  2  hours tens, 24h BCD (0..2)
h_ones  input  4  hours ones, BCD
m_tens  input  3  minutes tens, BCD (0..5)
m_ones  input  4  minutes ones, BCD
s_tens  input  3  seconds tens, BCD (0..5)
s_ones  input  4  seconds ones, BCD
hour_12h  input  1  1 = 12h display with PM flag
force_refresh  input  1  single-tick request for a frame
seg7  output  7  segment bus {a,b,c,d,e,f,g}, active high
le  output  6  latch enables; bit0=Ht, 1=Ho, 2=Mt, 3=Mo, 4=St, 5=So
pm  output  1  PM indicator
busy  output  1  high while a frame is in progress

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered. Reset values: seg7=0, le=0, pm=0, busy=0. Reset also sets state to IDLE, clears the refresh counter, and sets the pending flag so that a frame starts right after reset.
- States:
  - IDLE: seg7=0, le=0.
  - LOAD: 1 tick.
  - SCAN: idx 0..5, one tick per digit.
- IDLE -> LOAD when any of these is true at a posedge:
  - pending flag set
  - force_refresh=1
  - live inputs (all digits plus hour_12h) differ from the snapshot
  - REFRESH_TICKS != 0 and refresh counter == REFRESH_TICKS-1
- LOAD, on its posedge:
  - snapshot all inputs and compute the display hours and pm
  - clear pending, clear the refresh counter
  - set busy=1, go to SCAN idx=0
- SCAN, per tick:
  - seg7 = pattern(digit[idx]), le = (1<<idx), both valid in the same tick
  - idx advances each tick
  - after idx=5, state returns to IDLE; seg7, le and busy return to 0 on that posedge
- Latency: if the trigger is sampled true at edge k, le[0] is high when sampled at edge k+2 and le[5] at edge k+7. A frame is 7 ticks. Back-to-back frames are separated by at least 1 IDLE tick.
- Inputs that change during LOAD/SCAN do not affect the current frame. The snapshot compare in IDLE then triggers a new frame.
- force_refresh pulses during a frame set the pending flag; they are not lost.
- The refresh counter increments every IDLE tick and saturates at REFRESH_TICKS-1.
- 12h conversion, with H = h_tens*10 + h_ones:
  - H=0 -> 12, pm=0
  - H=1..11 -> H, pm=0
  - H=12 -> 12, pm=1
  - H=13..23 -> H-12, pm=1
- 12h display always shows a leading zero (01, not " 1").
- hour_12h=0: hours are passed through unchanged and pm=0.
- H>23 or an invalid BCD hour: both hour digits are treated as invalid and pm=0.
- pm updates only at LOAD.
- Segment patterns:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - invalid digit: per BLANK_INVALID
- Reset asserted mid-frame: outputs are 0 on the next posedge, the frame is abandoned, and a fresh frame starts after reset is released.

Test Plan:
- Reset 5 ticks with inputs 12:34:56, hour_12h=0, then release -> le strobes 0..5 in consecutive ticks starting 2 ticks after release; decoded latches read 12,34,56; pm=0; busy high for exactly 6 ticks.
- Steady inputs, REFRESH_TICKS=20 -> a frame every 20 IDLE ticks plus frame length; no frame in between; seg7=0 whenever le=0.
- Change s_ones 6->7 in IDLE -> new frame, le[0] is sampled high 2 edges after the change, So latch = 7. Change s_ones during SCAN idx=2 -> the current frame shows the old value and the next frame follows 1 IDLE tick later with the new value.
- hour_12h=1 with H = 00, 11, 12, 13, 23 -> displays 12/0, 11/0, 12/1, 01/1, 11/1 (hours/pm).
- h_ones=4'hB (BLANK_INVALID=1) -> Ho strobed with seg7=0000000. force_refresh pulsed at SCAN idx=3 -> exactly one extra frame after the current one.
- Assert rst at SCAN idx=2 -> le=0 and seg7=0 the next tick; after release a complete 6-strobe frame occurs.
